// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared muldiv types and constants (state enum, widths, mode encodings)
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int MD_WIDTH = 16;
  localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);

  localparam logic MD_UNSIGNED = 1'b0;
  localparam logic MD_SIGNED   = 1'b1;

endpackage

// File: rtl/seq_divider16_div_step.sv
// rtl/seq_divider16_div_step.sv - one combinational restoring division iteration
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Shift the next dividend bit in, trial-subtract with an extra bit for the borrow,
  // keep the difference when non-negative, otherwise restore the shifted value.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider16.sv
// rtl/seq_divider16.sv - iterative restoring divider, 1 quotient bit/cycle; DIVIDER_REM_EN adds rem output
module seq_divider16
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             work,
  output logic             rdy,
  output logic [WIDTH-1:0] result
`ifdef DIVIDER_REM_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  localparam int              CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q;      // dividend magnitude, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dsr_q;      // divisor magnitude
  logic [WIDTH-1:0] prem_q;     // working partial remainder
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quot_q;
  logic             div_zero_q;
`ifdef DIVIDER_REM_EN
  logic             neg_rem_q;
  logic [WIDTH-1:0] rem_fixed;
`endif

  logic             load;
  logic             last_step;
  logic [WIDTH-1:0] num1_mag;
  logic [WIDTH-1:0] num2_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] quot_fixed;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (prem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // Operand magnitudes at latch time; 0x8000 stays 0x8000 and is then treated as unsigned.
  always_comb begin
    num1_mag = (mode == MD_SIGNED && num1[WIDTH-1]) ? ({WIDTH{1'b0}} - num1) : num1;
    num2_mag = (mode == MD_SIGNED && num2[WIDTH-1]) ? ({WIDTH{1'b0}} - num2) : num2;
  end

  // Final quotient and sign fix-up; divide by zero forces all-ones regardless of signs.
  always_comb begin
    load       = (state_q == IDLE) && start;
    last_step  = (state_q == CALC) && (cnt_q == LAST_STEP);
    quot_next  = {dvd_q[WIDTH-2:0], step_qbit};
    quot_fixed = neg_quot_q ? ({WIDTH{1'b0}} - quot_next) : quot_next;
    if (div_zero_q) begin
      quot_fixed = {WIDTH{1'b1}};
    end
  end

`ifdef DIVIDER_REM_EN
  // Remainder follows the dividend sign; for a zero divisor this restores num1 exactly.
  always_comb begin
    rem_fixed = neg_rem_q ? ({WIDTH{1'b0}} - step_rem) : step_rem;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; work is combinational in the start cycle so the stall begins at once.
  always_comb begin
    state_d = state_q;
    work    = 1'b0;
    rdy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        work = 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rdy     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accepted start, iterate in CALC, publish results as DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q      <= '0;
      dsr_q      <= '0;
      prem_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      div_zero_q <= 1'b0;
      result     <= '0;
`ifdef DIVIDER_REM_EN
      neg_rem_q  <= 1'b0;
      rem        <= '0;
`endif
    end else begin
      if (load) begin
        dvd_q      <= num1_mag;
        dsr_q      <= num2_mag;
        prem_q     <= '0;
        cnt_q      <= '0;
        neg_quot_q <= (mode == MD_SIGNED) && (num1[WIDTH-1] ^ num2[WIDTH-1]);
        div_zero_q <= (num2 == '0);
`ifdef DIVIDER_REM_EN
        neg_rem_q  <= (mode == MD_SIGNED) && num1[WIDTH-1];
`endif
      end else if (state_q == CALC) begin
        dvd_q  <= quot_next;
        prem_q <= step_rem;
        cnt_q  <= cnt_q + 1'b1;
        if (last_step) begin
          result <= quot_fixed;
`ifdef DIVIDER_REM_EN
          rem    <= rem_fixed;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// tb/tb_seq_divider16.sv - directed self-checking bench for seq_divider16 (rem checks when DIVIDER_REM_EN)
module tb_seq_divider16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] num1;
  logic [15:0] num2;
  logic        work;
  logic        rdy;
  logic [15:0] result;
`ifdef DIVIDER_REM_EN
  logic [15:0] rem;
`endif

  int n_cmp;
  int n_bad;

  seq_divider16 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .num1   (num1),
    .num2   (num2),
    .work   (work),
    .rdy    (rdy),
    .result (result)
`ifdef DIVIDER_REM_EN
    ,
    .rem    (rem)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one divide in the current cycle and follow it until rdy plus two cycles.
  // hold=1 keeps start high with changing operands through CALC and DONE.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic m, input logic hold,
                        output logic [15:0] res, output logic [15:0] remv, output int lat,
                        output int n_rdy, output logic seq_ok);
    logic [15:0] res_before;
    @(posedge clk); #1;
    res_before = result;
    num1 = a; num2 = b; mode = m; start = 1'b1;
    #1;
    seq_ok = work;
    lat = -1; n_rdy = 0; res = 16'h0; remv = 16'h0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rdy) begin
        n_rdy++;
        if (lat < 0) begin
          lat = k;
          res = result;
`ifdef DIVIDER_REM_EN
          remv = rem;
`endif
        end
      end
      if (k <= 16 && !work) seq_ok = 1'b0;
      if (lat > 0 && k <= lat + 1 && k >= lat && work) seq_ok = 1'b0;
      if (lat < 0 && result !== res_before) seq_ok = 1'b0;
      if (hold && lat < 0) begin
        start = 1'b1;
        num1  = 16'(k * 37 + 5);
        num2  = 16'(k + 2);
        mode  = k[0];
      end else begin
        start = 1'b0;
      end
      if (lat > 0 && k >= lat + 2) break;
    end
    start = 1'b0;
  endtask

  logic [15:0] r, rm;
  int          lat, nr;
  logic        ok;

  task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m,
                          input logic [15:0] exp_q, input logic [15:0] exp_r);
    do_div(a, b, m, 1'b0, r, rm, lat, nr, ok);
    check({tag, ".result"}, r, exp_q);
    check({tag, ".latency"}, lat, 17);
    check({tag, ".rdy_count"}, nr, 1);
    check({tag, ".work_seq"}, ok, 1'b1);
`ifdef DIVIDER_REM_EN
    check({tag, ".rem"}, rm, exp_r);
`else
    if (exp_r === 16'hxxxx) $display("unused remainder");
`endif
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; num1 = '0; num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.result", result, 16'h0000);
    check("reset.rdy", rdy, 1'b0);
    check("reset.work", work, 1'b0);
`ifdef DIVIDER_REM_EN
    check("reset.rem", rem, 16'h0000);
`endif
    rst = 1'b0;

    run_case("u_100_7",      16'd100,  16'd7,    1'b0, 16'd14,   16'd2);
    run_case("s_m100_7",     16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE);
    run_case("s_100_m7",     16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002);
    run_case("u_div0",       16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234);
    run_case("s_div0",       16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234);
    run_case("s_div0_neg",   16'hFF9C, 16'h0000, 1'b1, 16'hFFFF, 16'hFF9C);
    run_case("s_ovf",        16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000);
    run_case("u_8000_ffff",  16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000);
    run_case("u_ffff_1",     16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000);

    // start held with changing operands: only the first request counts
    do_div(16'd50, 16'd5, 1'b0, 1'b1, r, rm, lat, nr, ok);
    check("hold.result", r, 16'd10);
    check("hold.latency", lat, 17);
    check("hold.rdy_count", nr, 1);
    check("hold.work_seq", ok, 1'b1);
    @(posedge clk); #1;
    check("hold.result_kept", result, 16'd10);
    check("hold.idle_work", work, 1'b0);

    // asynchronous reset in the middle of 100/7
    @(posedge clk); #1;
    num1 = 16'd100; num2 = 16'd7; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst.busy_before", work, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst.result", result, 16'h0000);
    check("midrst.rdy", rdy, 1'b0);
    check("midrst.work", work, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_case("after_rst_9_3", 16'd9, 16'd3, 1'b0, 16'd3, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
